// File: rtl/chan_blk_arbiter_pkg.sv
// Shared block-format definitions for the channel block arbiter: control-word
// field positions, block types, FSM state type and the header validity rule.
package chan_blk_arbiter_pkg;

    localparam int WORD_W     = 16;
    localparam int CW_FLAG    = 15;
    localparam int CW_CH_MSB  = 14;
    localparam int CW_CH_LSB  = 9;
    localparam int CW_LEN_MSB = 8;
    localparam int CW_LEN_LSB = 0;
    localparam int MIN_LEN    = 3;

    localparam int BT_SELF = 0;
    localparam int BT_RAW  = 3;
    localparam int BT_PAIR = 6;

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_BODY = 1'b1
    } arb_state_t;

    // A control word needs its flag, a length of at least MIN_LEN and,
    // when chk_en is set, the channel number the arbiter is pointing at.
    function automatic logic cw_ok(input logic [WORD_W-1:0] w,
                                   input logic [5:0]        ch_exp,
                                   input logic              chk_en);
        logic ok;
        ok = w[CW_FLAG] && (w[CW_LEN_MSB:CW_LEN_LSB] >= 9'(MIN_LEN));
        if (chk_en && (w[CW_CH_MSB:CW_CH_LSB] != ch_exp))
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/arb_word_mux.sv
// Combinational NCH:1 selector of the 16-bit channel dout bus by the arbiter pointer.
module arb_word_mux
    import chan_blk_arbiter_pkg::*;
#(
    parameter int NCH = 16,
    parameter int PW  = 4
) (
    input  logic [WORD_W*NCH-1:0] din,
    input  logic [PW-1:0]         sel,
    output logic [WORD_W-1:0]     word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == PW'(i))
                word = din[WORD_W*i +: WORD_W];
        end
    end

endmodule

// File: rtl/chan_blk_arbiter.sv
// Round-robin reader of channel blocks onto one 16-bit stream, with header and
// mid-block timeout checks. Optional channel-number check: ARB_CHNUM_CHECK_EN.
module chan_blk_arbiter
    import chan_blk_arbiter_pkg::*;
#(
    parameter int NCH    = 16,
    parameter int TOUT   = 64,
    parameter int CHBASE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [NCH-1:0]        give,
    input  logic [NCH-1:0]        have,
    input  logic [WORD_W*NCH-1:0] din,
    input  logic                  oready,
    output logic [WORD_W-1:0]     odata,
    output logic                  ovalid,
    output logic                  osop,
    output logic                  oeop,
    output logic                  oabort,
    output logic                  err_hdr,
    output logic                  err_to
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = $clog2(TOUT + 1);

`ifdef ARB_CHNUM_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    arb_state_t        state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_next;
    logic [8:0]        cnt;
    logic [TW-1:0]     tout;
    logic              run;
    logic              give_on;
    logic              xfer;
    logic              hdr_good;
    logic [5:0]        ch_exp;
    logic [WORD_W-1:0] word;

    arb_word_mux #(
        .NCH (NCH),
        .PW  (PW)
    ) u_mux (
        .din  (din),
        .sel  (ptr),
        .word (word)
    );

    // run holds give low for the first cycle out of reset so every output reads 0 in reset.
    assign give_on  = run & oready;
    assign xfer     = |(give & have);
    assign ptr_next = (ptr == PW'(NCH - 1)) ? '0 : ptr + 1'b1;
    assign ch_exp   = 6'(CHBASE) + 6'(ptr);
    assign hdr_good = cw_ok(word, ch_exp, CHK_EN);

    always_comb begin
        give = '0;
        for (int i = 0; i < NCH; i++)
            give[i] = give_on && (ptr == PW'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_SCAN;
            ptr     <= '0;
            cnt     <= '0;
            tout    <= '0;
            run     <= 1'b0;
            odata   <= '0;
            ovalid  <= 1'b0;
            osop    <= 1'b0;
            oeop    <= 1'b0;
            oabort  <= 1'b0;
            err_hdr <= 1'b0;
            err_to  <= 1'b0;
        end else begin
            run     <= 1'b1;
            odata   <= '0;
            ovalid  <= 1'b0;
            osop    <= 1'b0;
            oeop    <= 1'b0;
            oabort  <= 1'b0;
            err_hdr <= 1'b0;
            err_to  <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (give_on) begin
                        if (xfer && hdr_good) begin
                            odata  <= word;
                            ovalid <= 1'b1;
                            osop   <= 1'b1;
                            cnt    <= word[CW_LEN_MSB:CW_LEN_LSB];
                            tout   <= '0;
                            state  <= ST_BODY;
                        end else begin
                            // Empty channel or rejected header: move on either way.
                            err_hdr <= xfer;
                            ptr     <= ptr_next;
                        end
                    end
                end
                ST_BODY: begin
                    if (give_on) begin
                        if (xfer) begin
                            odata  <= word;
                            ovalid <= 1'b1;
                            cnt    <= cnt - 9'd1;
                            tout   <= '0;
                            if (cnt == 9'd1) begin
                                oeop  <= 1'b1;
                                ptr   <= ptr_next;
                                state <= ST_SCAN;
                            end
                        end else if (tout == TW'(TOUT - 1)) begin
                            ovalid <= 1'b1;
                            oeop   <= 1'b1;
                            oabort <= 1'b1;
                            err_to <= 1'b1;
                            tout   <= '0;
                            ptr    <= ptr_next;
                            state  <= ST_SCAN;
                        end else begin
                            tout <= tout + 1'b1;
                        end
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

endmodule
